fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/riscv_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/fetch_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 front-end definitions: default address width, NOP encoding,
// and the layout of a fetched entry.
`default_nettype none

package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [31:0]             instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO with register-sourced head output, occupancy
// count and a flush that overrides push and pop.
`default_nettype none

module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int                WIDTH = 64,
  parameter int                DEPTH = 4,
  parameter logic [WIDTH-1:0]  INIT  = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign do_pop  = pop & valid;
  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign do_push = push & ((count < CW'(DEPTH)) | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= INIT;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited in-order requests to instruction memory,
// response buffering, and redirect handling with stale-response dropping.
`default_nettype none

module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fetch_pc_nxt;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] target;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   out_nxt;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic [CW:0]     credit_sum;
  logic            credit_ok;
  logic            stale;
  logic            grant;
  logic            stalled;
  logic            kept;
  logic            push;
  logic            pop;

  assign target  = redirect_pc & ~XLEN'(3);
  assign grant   = imem_req & imem_gnt;
  assign stalled = imem_req & ~imem_gnt;
  assign kept    = imem_rvalid & (drop == '0);
  assign push    = kept & ~redirect_valid;
  assign pop     = id_valid & id_ready;

  always_comb begin
    out_nxt = outstanding + CW'(grant) - CW'(imem_rvalid);
    cnt_nxt = redirect_valid ? '0 : (cnt + CW'(push) - CW'(pop));
    // A stale grant belongs to the old stream, so it must not advance the new target.
    fetch_pc_nxt = fetch_pc;
    if (redirect_valid) begin
      fetch_pc_nxt = target;
    end else if (grant & ~stale) begin
      fetch_pc_nxt = fetch_pc + XLEN'(4);
    end
    credit_sum = {1'b0, out_nxt} + {1'b0, cnt_nxt};
    credit_ok  = credit_sum < (CW + 1)'(DEPTH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      stale       <= 1'b0;
    end else begin
      outstanding <= out_nxt;
      fetch_pc    <= fetch_pc_nxt;
      if (!stalled) begin
        imem_req  <= credit_ok;
        imem_addr <= fetch_pc_nxt;
      end
      if (redirect_valid) begin
        resp_pc <= target;
      end else if (kept) begin
        resp_pc <= resp_pc + XLEN'(4);
      end
      if (redirect_valid) begin
        drop <= out_nxt;
      end else begin
        drop <= drop - CW'(imem_rvalid && (drop != '0)) + CW'(grant & stale);
      end
      if (stalled & redirect_valid) begin
        stale <= 1'b1;
      end else if (grant) begin
        stale <= 1'b0;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (XLEN + 32),
    .DEPTH (DEPTH),
    .INIT  ({{XLEN{1'b0}}, NOP})
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .din   ({resp_pc, imem_rdata}),
    .pop   (pop),
    .dout  ({id_pc, id_instr}),
    .valid (id_valid),
    .count (cnt)
  );

endmodule

`default_nettype wire
